inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter INST_LEN, default 17: instruction width in bits.
REQ-002 SHALL have parameter INST_CAP, default 5: instruction-memory address width; depth is 2^INST_CAP words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid, input, 1 bit: byte-stream valid.
REQ-007 SHALL have port in_data, input, 8 bits: byte-stream data.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port mem_w_en, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port mem_w_addr, output, INST_CAP bits: write address.
REQ-011 SHALL have port mem_w_data, output, INST_LEN bits: write data.
REQ-012 SHALL have port core_hold, output, 1 bit: keeps the pipeline in reset while high.
REQ-013 SHALL have port done, output, 1 bit: load completed successfully.
REQ-014 SHALL have port err, output, 1 bit: load aborted on a framing error.

Function
REQ-015 SHALL implement states IDLE, COUNT, B0, B1, B2, WRITE, DONE, ERR.
REQ-016 SHALL transfer a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready=1 only in COUNT, B0, B1 and B2.
REQ-018 IDLE: SHALL go to COUNT when start=1; core_hold=1.
REQ-019 COUNT: the accepted byte is N, the instruction count.
 - N=0 or N>2^INST_CAP: go to ERR.
 - Otherwise: store N, clear the word index, go to B0.
REQ-020 B0, B1 and B2: each accepts one byte, little-endian, forming a 24-bit word.
 - B0 to B1 to B2 to WRITE.
REQ-021 At B2 acceptance: if word bits [23:INST_LEN] are nonzero, SHALL go to ERR instead of WRITE.
REQ-022 WRITE: SHALL pulse mem_w_en for exactly one cycle, with:
 - mem_w_addr = word index;
 - mem_w_data = word[INST_LEN-1:0].
REQ-023 After WRITE: increment the index; go to B0 if index+1<N, else go to DONE.
REQ-024 With in_valid held high, each instruction SHALL take 4 cycles (3 byte cycles plus 1 WRITE cycle).
REQ-025 in_valid low in COUNT or B0 to B2 SHALL stall in place, holding all partial state.
REQ-026 DONE: done=1, core_hold=0; hold until start=1, then clear done and go to COUNT.
REQ-027 ERR: err=1, core_hold=1, mem_w_en=0; hold until start=1, then clear err and go to COUNT.
REQ-028 start SHALL be ignored in COUNT, B0, B1, B2 and WRITE.
REQ-029 mem_w_addr and mem_w_data SHALL be zero whenever mem_w_en=0.
REQ-030 The index SHALL NOT wrap: N=2^INST_CAP writes addresses 0 to 2^INST_CAP-1 exactly once.
REQ-031 Words already written before an ERR SHALL NOT be rolled back.

Reset
REQ-032 rst=1 SHALL force, at the next edge:
 - state=IDLE, index=0, N=0, byte buffer=0;
 - in_ready=0, mem_w_en=0, mem_w_addr=0, mem_w_data=0;
 - done=0, err=0, core_hold=1.
REQ-033 rst SHALL take priority over start and in_valid in every state, including mid-word and during WRITE.

Verification
REQ-034 Basic load: rst, start, bytes 02, 34,12,00, 01,00,01, with in_valid continuous.
 - Writes addr0=0x01234, addr1=0x10001, one cycle each.
 - done=1, core_hold=0 one cycle after the second write.
REQ-035 Stall: N=1, with in_valid dropped 3 cycles between B0 and B1.
 - The single write occurs 3 cycles later than the unstalled case, with the same data.
REQ-036 Framing error: N=1, bytes FF,FF,FF (bit 17 set).
 - No write, err=1, core_hold=1.
 - A following start with N=1, bytes 05,00,00 writes addr0=0x00005, then done=1.
REQ-037 Bounds (INST_CAP=5):
 - N=00: ERR.
 - N=33: ERR.
 - N=32: exactly 32 writes, addresses 0 to 31, then done.
REQ-038 Reset mid-operation: rst during B1 of word 2.
 - Next cycle: IDLE, in_ready=0, mem_w_en=0, core_hold=1, done=0.
 - Words 0 and 1 are not rewritten.
REQ-039 Back-to-back: start pulsed in DONE.
 - done falls next cycle, in_ready=1 in COUNT.
 - A new N=1 load completes.

Source files
------------

// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Loads an instruction image from a byte stream into instruction memory.
// The stream carries a count byte N, then N instructions of three bytes
// each (little-endian, 24 bits).  Each instruction is truncated to INST_LEN
// bits and written to consecutive addresses starting at 0.  The core is
// held in reset (core_hold=1) until a load completes without error.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   start      - one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid   - byte-stream valid
//   in_data    - byte-stream data (8 bits)
//   in_ready   - loader accepts a byte this cycle
//   mem_w_en   - instruction-memory write strobe (one cycle per word)
//   mem_w_addr - write address (zero when mem_w_en=0)
//   mem_w_data - write data (zero when mem_w_en=0)
//   core_hold  - keeps the pipeline in reset while high
//   done       - load completed successfully
//   err        - load aborted (bad count or oversized word)
// ---------------------------------------------------------------------------
module inst_loader #(
  parameter int INST_LEN = 17,
  parameter int INST_CAP = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_w_en,
  output logic [INST_CAP-1:0] mem_w_addr,
  output logic [INST_LEN-1:0] mem_w_data,
  output logic                core_hold,
  output logic                done,
  output logic                err
);

  // One extra index bit so the index can reach 2^INST_CAP after the last
  // write without wrapping back to zero.
  localparam int IDX_W = INST_CAP + 1;
  localparam int DEPTH = 1 << INST_CAP;

  typedef enum logic [2:0] {
    IDLE, COUNT, B0, B1, B2, WRITE, DONE, ERR
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [7:0]          count_reg, count_next;
  logic [7:0]          b0_reg, b0_next;
  logic [7:0]          b1_reg, b1_next;
  logic [INST_LEN-1:0] word_reg, word_next;

  logic [23:0]         word_full;
  logic                word_overflow;
  logic                count_bad;
  logic [IDX_W-1:0]    idx_inc;
  logic                more_words;

  // Complete little-endian word as it would be on the B2 acceptance cycle.
  assign word_full     = {in_data, b1_reg, b0_reg};
  assign word_overflow = (word_full >> INST_LEN) != 24'd0;
  assign count_bad     = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign idx_inc       = idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};
  assign more_words    = 32'(idx_inc) < 32'(count_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      count_reg <= '0;
      b0_reg    <= '0;
      b1_reg    <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      b0_reg    <= b0_next;
      b1_reg    <= b1_next;
      word_reg  <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    b0_next    = b0_reg;
    b1_next    = b1_reg;
    word_next  = word_reg;
    in_ready   = 1'b0;
    mem_w_en   = 1'b0;
    mem_w_addr = '0;
    mem_w_data = '0;
    core_hold  = 1'b1;
    done       = 1'b0;
    err        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = COUNT;
      end
      COUNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count_bad) begin
            state_next = ERR;
          end else begin
            count_next = in_data;
            idx_next   = '0;
            state_next = B0;
          end
        end
      end
      B0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b0_next    = in_data;
          state_next = B1;
        end
      end
      B1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b1_next    = in_data;
          state_next = B2;
        end
      end
      B2: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (word_overflow) begin
            state_next = ERR;
          end else begin
            word_next  = word_full[INST_LEN-1:0];
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        mem_w_en   = 1'b1;
        mem_w_addr = idx_reg[INST_CAP-1:0];
        mem_w_data = word_reg;
        idx_next   = idx_inc;
        state_next = more_words ? B0 : DONE;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_next = COUNT;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_next = COUNT;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
